// File: rtl/sample_pkg.sv
// Stereo sample payload shared by the I2S transceiver and the effect chain.
package sample_pkg;
  localparam int unsigned SAMPLE_W = 24;

  typedef struct packed {
    logic [SAMPLE_W-1:0] lc;
    logic [SAMPLE_W-1:0] rc;
  } sample_t;
endpackage

// File: rtl/fx_sched.sv
// Start-up sequencer and per-sample deadline scheduler between the I2S
// transceiver and the effect engine.
module fx_sched #(
  parameter int unsigned RST_CYCLES  = 64,
  parameter int unsigned MUTE_FRAMES = 4096,
  parameter int unsigned DEADLINE    = 448,
  parameter int unsigned OVR_W       = 16
) (
  input  logic                mclk,
  input  logic                rst,
  output logic                i2s_rst,
  input  sample_pkg::sample_t rx_data,
  input  logic                rx_vld,
  output sample_pkg::sample_t tx_data,
  output logic                tx_vld,
  input  logic                bypass,
  output sample_pkg::sample_t fx_in,
  output logic                fx_in_vld,
  input  logic                fx_in_rdy,
  input  sample_pkg::sample_t fx_out,
  input  logic                fx_out_vld,
  output logic                fx_flush,
  output logic                overrun,
  output logic [OVR_W-1:0]    overrun_cnt,
  output logic                muted
);
  localparam int unsigned HOLD_W  = $clog2(RST_CYCLES + 1);
  localparam int unsigned FRAME_W = $clog2(MUTE_FRAMES + 1);
  localparam int unsigned DL_W    = $clog2(DEADLINE + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(MUTE_FRAMES - 1);
  localparam logic [DL_W-1:0]    DL_LAST    = DL_W'(DEADLINE - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_MUTE,
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
  logic [DL_W-1:0]     dl_cnt_q, dl_cnt_d;
  sample_pkg::sample_t dry_q, dry_d;
  sample_pkg::sample_t tx_data_q, tx_data_d;
  sample_pkg::sample_t fx_in_q, fx_in_d;
  logic                tx_vld_q, tx_vld_d;
  logic                fx_in_vld_q, fx_in_vld_d;
  logic                fx_flush_q, fx_flush_d;
  logic                overrun_q, overrun_d;
  logic [OVR_W-1:0]    ovr_cnt_q, ovr_cnt_d;
  logic                i2s_rst_q, i2s_rst_d;
  logic                muted_q, muted_d;
  logic                timeout_c;

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q     <= S_HOLD;
      hold_cnt_q  <= '0;
      frame_cnt_q <= '0;
      dl_cnt_q    <= '0;
      dry_q       <= '0;
      tx_data_q   <= '0;
      fx_in_q     <= '0;
      tx_vld_q    <= 1'b0;
      fx_in_vld_q <= 1'b0;
      fx_flush_q  <= 1'b0;
      overrun_q   <= 1'b0;
      ovr_cnt_q   <= '0;
      i2s_rst_q   <= 1'b1;
      muted_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      dl_cnt_q    <= dl_cnt_d;
      dry_q       <= dry_d;
      tx_data_q   <= tx_data_d;
      fx_in_q     <= fx_in_d;
      tx_vld_q    <= tx_vld_d;
      fx_in_vld_q <= fx_in_vld_d;
      fx_flush_q  <= fx_flush_d;
      overrun_q   <= overrun_d;
      ovr_cnt_q   <= ovr_cnt_d;
      i2s_rst_q   <= i2s_rst_d;
      muted_q     <= muted_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    frame_cnt_d = frame_cnt_q;
    dl_cnt_d    = dl_cnt_q;
    dry_d       = dry_q;
    tx_data_d   = tx_data_q;
    fx_in_d     = fx_in_q;
    tx_vld_d    = 1'b0;
    fx_in_vld_d = fx_in_vld_q;
    fx_flush_d  = 1'b0;
    overrun_d   = 1'b0;
    ovr_cnt_d   = ovr_cnt_q;
    i2s_rst_d   = i2s_rst_q;
    muted_d     = muted_q;
    timeout_c   = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          i2s_rst_d   = 1'b0;
          frame_cnt_d = '0;
          state_d     = S_MUTE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_MUTE: begin
        if (rx_vld) begin
          tx_vld_d  = 1'b1;
          tx_data_d = '0;
          if (frame_cnt_q == FRAME_LAST) begin
            muted_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
          end
        end
      end
      S_IDLE: begin
        if (rx_vld) begin
          if (bypass) begin
            tx_vld_d  = 1'b1;
            tx_data_d = rx_data;
          end else begin
            dry_d       = rx_data;
            fx_in_d     = rx_data;
            fx_in_vld_d = 1'b1;
            dl_cnt_d    = DL_W'(1);
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // A new frame or the deadline pre-empts a handshake in the same cycle.
        dl_cnt_d = dl_cnt_q + DL_W'(1);
        if (rx_vld || (dl_cnt_q == DL_LAST)) begin
          timeout_c = 1'b1;
        end else if (fx_in_rdy) begin
          fx_in_vld_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        dl_cnt_d = dl_cnt_q + DL_W'(1);
        if (fx_out_vld) begin
          tx_vld_d  = 1'b1;
          tx_data_d = fx_out;
          state_d   = S_IDLE;
        end else if (rx_vld || (dl_cnt_q == DL_LAST)) begin
          timeout_c = 1'b1;
        end
      end
      default: state_d = S_HOLD;
    endcase

    // Late engine: send the dry sample and discard the in-flight work.
    if (timeout_c) begin
      tx_vld_d    = 1'b1;
      tx_data_d   = dry_q;
      fx_flush_d  = 1'b1;
      overrun_d   = 1'b1;
      fx_in_vld_d = 1'b0;
      state_d     = S_IDLE;
      if (ovr_cnt_q != '1) begin
        ovr_cnt_d = ovr_cnt_q + OVR_W'(1);
      end
    end
  end

  assign i2s_rst     = i2s_rst_q;
  assign tx_data     = tx_data_q;
  assign tx_vld      = tx_vld_q;
  assign fx_in       = fx_in_q;
  assign fx_in_vld   = fx_in_vld_q;
  assign fx_flush    = fx_flush_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = ovr_cnt_q;
  assign muted       = muted_q;

endmodule
